// File: rtl/uart_rx_seq.sv
// uart_rx_seq: receive-side sequencer for the UART datapath.
//   A start_stb_i strobe (line fell 1->0) opens a frame. The baud counter times each bit
//   and rxd_i is sampled at mid-bit. The frame is start, DATA_BITS data bits (LSB first),
//   an optional parity bit and one stop bit. The result is reported by one registered
//   single-cycle pulse: rx_valid_o (good byte), frame_err_o or parity_err_o.
// Configuration macro: UART_RX_PARITY_EN adds an even-parity bit between the data and
//   the stop bit, and drives parity_err_o. When the macro is undefined, parity_err_o is
//   tied to 0.
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   rxd_i         serial line, already synchronised to clk; idle = 1
//   start_stb_i   1-cycle pulse on a 1->0 line transition
//   rx_data_o     last good byte; updated only together with rx_valid_o
//   rx_valid_o    1-cycle pulse: rx_data_o holds a new good byte
//   frame_err_o   1-cycle pulse: stop bit sampled as 0
//   busy_o        high whenever the sequencer is not idle
//   parity_err_o  1-cycle pulse: parity mismatch (parity builds only)
module uart_rx_seq #(
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd_i,
  input  logic                 start_stb_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 frame_err_o,
  output logic                 busy_o,
  output logic                 parity_err_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam int unsigned Half = CLK_DIV / 2;

  localparam logic [CntW-1:0] CntHalfLast = CntW'(Half - 1);
  localparam logic [CntW-1:0] CntBitLast  = CntW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast     = BitW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 cnt_last;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  assign cnt_last = (cnt_q == CntBitLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // Holding the counter at 0 means it is already cleared on entry to StStart.
        cnt_d = '0;
        bit_d = '0;
        if (start_stb_i) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntHalfLast) begin
          cnt_d   = '0;
          // A line that is high again at mid-start was a glitch: drop it silently.
          state_d = rxd_i ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_last) begin
          shift_d = {rxd_i, shift_q[DATA_BITS-1:1]};
          if (bit_q == BitLast) begin
            bit_d   = '0;
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_last) begin
          par_d   = rxd_i;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_last) begin
          state_d = StIdle;
          if (!rxd_i) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_q != ^shift_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
